// File: rtl/led_shift_ctrl.sv
// LED shifter controller: debounced single-cycle button commands, tick-paced shifting,
// all-lit detection with blinking blank output.
module led_shift_ctrl #(
  parameter int TICK_CYCLES     = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        btn_load_i,
  input  logic        btn_start_i,
  input  logic        btn_off_i,
  input  logic [15:0] leds_i,
  output logic        shift_o,
  output logic        load_o,
  output logic        off_o,
  output logic [2:0]  state_o
);
  // state  | meaning
  // IDLE   | blanked, waiting for load or start
  // LOAD   | one-cycle load command to the shifter
  // PAUSED | pattern held, no shifting
  // RUN    | shift once per tick until all LEDs lit
  // DONE   | all lit, display blinks once per tick
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_PAUSED = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  logic [2:0]    w_btn_raw;
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  logic [2:0]    w_press;
  state_t        r_state;
  state_t        w_state_next;
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  logic          w_ticking;
  logic          r_blink;
  logic          r_off_tgl;

  // Button index: 0 = load, 1 = start, 2 = off.
  assign w_btn_raw = {btn_off_i, btn_start_i, btn_load_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_btn
    logic [DW-1:0] r_db_cnt;
    logic          r_db_lvl;
    logic          r_db_prev;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_db_cnt  <= '0;
        r_db_lvl  <= 1'b0;
        r_db_prev <= 1'b0;
      end else begin
        r_db_prev <= r_db_lvl;
        if (r_sync2[g] == r_db_lvl) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == DEB_LAST) begin
          r_db_lvl <= ~r_db_lvl;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DW'(1);
        end
      end
    end

    assign w_press[g] = r_db_lvl & ~r_db_prev;
  end

  assign w_ticking = (r_state == S_RUN) || (r_state == S_DONE);
  assign w_tick    = w_ticking && (r_tick_cnt == TICK_LAST);

  // Any state change restarts the tick phase, so RUN entry always waits a full period.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tick_cnt <= '0;
    end else if ((w_state_next != r_state) || !w_ticking || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_blink   <= 1'b0;
      r_off_tgl <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state != S_DONE) begin
        r_blink <= 1'b0;
      end else if (w_tick) begin
        r_blink <= ~r_blink;
      end
      if (w_press[2]) begin
        r_off_tgl <= ~r_off_tgl;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    shift_o      = 1'b0;
    load_o       = 1'b0;
    case (r_state)
      S_IDLE, S_PAUSED: begin
        if (w_press[0])      w_state_next = S_LOAD;
        else if (w_press[1]) w_state_next = S_RUN;
      end
      S_LOAD: begin
        load_o       = 1'b1;
        w_state_next = S_PAUSED;
      end
      S_RUN: begin
        shift_o = w_tick & ~w_press[0] & ~w_press[1];
        if (w_press[0])              w_state_next = S_LOAD;
        else if (w_press[1])         w_state_next = S_PAUSED;
        else if (leds_i == 16'hFFFF) w_state_next = S_DONE;
      end
      S_DONE: begin
        if (w_press[0])      w_state_next = S_LOAD;
        else if (w_press[1]) w_state_next = S_PAUSED;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign state_o = r_state;
  assign off_o   = (r_state == S_IDLE) | ((r_state == S_DONE) & r_blink) | r_off_tgl;

endmodule

// File: tb/tb_led_shift_ctrl.sv
// Bench for led_shift_ctrl: directed and random button/LED stimulus against a
// cycle-indexed reference model built from acceptance windows and tick phase arithmetic.
module tb_led_shift_ctrl;
  localparam int TICK = 4;
  localparam int DEB  = 3;
  localparam int S_IDLE = 0, S_LOAD = 1, S_PAUSED = 2, S_RUN = 3, S_DONE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_load = 1'b0, btn_start = 1'b0, btn_off = 1'b0;
  logic [15:0] leds = 16'h0000;
  logic        shift, load, off;
  logic [2:0]  state;

  led_shift_ctrl #(.TICK_CYCLES(TICK), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .btn_load_i(btn_load), .btn_start_i(btn_start), .btn_off_i(btn_off),
    .leds_i(leds),
    .shift_o(shift), .load_o(load), .off_o(off), .state_o(state)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 8;

  // Reference model: state plus the cycle index at which it was entered.
  int m_state, m_entry;
  bit m_tgl;
  bit m_lvl[3];
  bit m_press[3];
  bit m_hist[3][8];
  bit leds_full = 1'b0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit m_tick();
    return (m_state == S_RUN || m_state == S_DONE) && ((cyc - m_entry) % TICK == TICK - 1);
  endfunction

  function automatic bit m_off();
    return (m_state == S_IDLE) || m_tgl ||
           (m_state == S_DONE && ((cyc - m_entry) / TICK) % 2 == 1);
  endfunction

  task automatic check_outputs();
    check("state", 16'(state), 16'(m_state));
    check("load",  16'(load),  16'(m_state == S_LOAD));
    check("shift", 16'(shift), 16'(m_state == S_RUN && m_tick() && !m_press[0] && !m_press[1]));
    check("off",   16'(off),   16'(m_off()));
  endtask

  task automatic model_reset();
    m_state = S_IDLE;
    m_entry = cyc;
    m_tgl   = 1'b0;
    for (int b = 0; b < 3; b++) begin
      m_lvl[b]   = 1'b0;
      m_press[b] = 1'b0;
      for (int k = 0; k < 8; k++) m_hist[b][k] = 1'b0;
    end
  endtask

  // Called at the clock edge that ends cycle 'cyc'.
  task automatic model_edge();
    int         nst;
    logic [2:0] raw;
    bit         flip;
    nst = m_state;
    case (m_state)
      S_IDLE, S_PAUSED: begin
        if (m_press[0])      nst = S_LOAD;
        else if (m_press[1]) nst = S_RUN;
      end
      S_LOAD: nst = S_PAUSED;
      S_RUN: begin
        if (m_press[0])            nst = S_LOAD;
        else if (m_press[1])       nst = S_PAUSED;
        else if (leds == 16'hFFFF) nst = S_DONE;
      end
      S_DONE: begin
        if (m_press[0])      nst = S_LOAD;
        else if (m_press[1]) nst = S_PAUSED;
      end
      default: nst = S_IDLE;
    endcase
    if (m_press[2]) m_tgl = !m_tgl;
    if (nst != m_state) begin
      m_state = nst;
      m_entry = cyc + 1;
    end
    // A level is accepted once DEB consecutive samples, seen two edges late, all differ from it.
    raw = {btn_off, btn_start, btn_load};
    for (int b = 0; b < 3; b++) begin
      m_hist[b][cyc % 8] = raw[b];
      flip = 1'b1;
      for (int k = 2; k <= DEB + 1; k++)
        if (m_hist[b][(cyc - k) % 8] == m_lvl[b]) flip = 1'b0;
      m_press[b] = 1'b0;
      if (flip) begin
        m_lvl[b]   = !m_lvl[b];
        m_press[b] = m_lvl[b];
      end
    end
    cyc++;
  endtask

  task automatic step();
    leds = leds_full ? 16'hFFFF : 16'($urandom_range(0, 32'hFFFE));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
  endtask

  task automatic btn_set(input int b, input bit v);
    case (b)
      0:       btn_load  = v;
      1:       btn_start = v;
      default: btn_off   = v;
    endcase
  endtask

  task automatic bounce_to(input int b, input bit v, input int nb);
    for (int i = 0; i < nb; i++) begin
      btn_set(b, (i % 2 == 0) ? v : !v);
      repeat ($urandom_range(1, DEB - 1)) step();
    end
    btn_set(b, v);
  endtask

  task automatic press(input int b);
    bounce_to(b, 1'b1, $urandom_range(0, 4));
    repeat (DEB + 4) step();
    bounce_to(b, 1'b0, $urandom_range(0, 4));
    repeat (DEB + 4) step();
  endtask

  task automatic wait_state(input int s, input string tag, output int n);
    n = 0;
    while (state !== 3'(s) && n < 40) begin
      step();
      n++;
    end
    check(tag, 16'(state), 16'(s));
  endtask

  initial begin
    int          n;
    logic [15:0] mask;

    @(negedge clk);
    do_reset();
    repeat (3) step();

    // Bouncing start: 2-cycle glitches, then a stable rise accepted 2+DEB+1 edges later.
    for (int i = 0; i < 6; i++) begin
      btn_start = (i % 2 == 0);
      repeat (2) step();
    end
    btn_start = 1'b1;
    wait_state(S_RUN, "deb_run", n);
    check("deb_latency", 16'(n), 16'(2 + DEB + 1));
    btn_start = 1'b0;
    repeat (10) step();

    // Load from IDLE.
    do_reset();
    btn_load = 1'b1;
    wait_state(S_LOAD, "load_enter", n);
    check("load_pulse", 16'(load), 16'd1);
    step();
    check("load_paused", 16'(state), 16'(S_PAUSED));
    check("load_off", 16'(off), 16'd0);
    check("load_once", 16'(load), 16'd0);
    btn_load = 1'b0;
    repeat (8) step();

    // Run pacing from PAUSED: shifts in RUN cycles 3, 7, 11 (ticks 4, 8, 12 edges after entry).
    btn_start = 1'b1;
    wait_state(S_RUN, "run_enter", n);
    btn_start = 1'b0;
    mask = '0;
    mask[0] = shift;
    for (int k = 1; k < 13; k++) begin
      step();
      mask[k] = shift;
    end
    check("run_shift_mask", mask, 16'h0888);

    // Off toggle on, then off again.
    press(2);
    press(2);

    // All lit: DONE next cycle, then blink 0000 1111 0000.
    leds_full = 1'b1;
    step();
    leds_full = 1'b0;
    check("done_enter", 16'(state), 16'(S_DONE));
    mask = '0;
    mask[0] = off;
    for (int k = 1; k < 12; k++) begin
      step();
      mask[k] = off;
    end
    check("blink_mask", mask, 16'h00F0);

    // DONE -> PAUSED -> RUN, then simultaneous load and start: load wins.
    press(1);
    check("done_pause", 16'(state), 16'(S_PAUSED));
    btn_start = 1'b1;
    wait_state(S_RUN, "rerun", n);
    btn_start = 1'b0;
    repeat (10) step();
    btn_load  = 1'b1;
    btn_start = 1'b1;
    n = 0;
    while (state === 3'(S_RUN) && n < 40) begin
      step();
      n++;
    end
    check("prio_load", 16'(state), 16'(S_LOAD));
    step();
    check("prio_paused", 16'(state), 16'(S_PAUSED));
    btn_load  = 1'b0;
    btn_start = 1'b0;
    repeat (8) step();

    // Reset mid-RUN and mid-debounce.
    press(1);
    repeat (2) step();
    do_reset();
    repeat (3) step();
    btn_start = 1'b1;
    repeat (2) step();
    do_reset();
    repeat (10) step();
    btn_start = 1'b0;
    repeat (8) step();

    // Random button traffic and LED feedback.
    for (int it = 0; it < 60; it++) begin
      press($urandom_range(0, 2));
      if ($urandom_range(0, 5) == 0) begin
        leds_full = 1'b1;
        repeat ($urandom_range(1, 3)) step();
        leds_full = 1'b0;
      end
      repeat ($urandom_range(0, 6)) step();
      if ($urandom_range(0, 19) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
